// File: rtl/spi_master_core.sv
`timescale 1ns/1ps
// Byte-wide SPI master engine: all four CPOL/CPHA modes, SCK half-period of D+1 clk cycles,
// automatic or manual chip select, valid/ready byte input and strobed byte output.
//   state | meaning
//   IDLE  | SCK tracks config_cpol, ready for a byte
//   SETUP | CS asserted, first MOSI bit presented for D+1 cycles
//   SHIFT | 16 SCK edges, D+1 cycles apart
//   HOLD  | SCK at cpol for D+1 cycles, then rx_data/rx_valid
module spi_master_core #(
  parameter int CLOCK_DIV_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       config_enable,
  input  logic [CLOCK_DIV_WIDTH-1:0] config_clockDivider,
  input  logic                       config_cpol,
  input  logic                       config_cpha,
  input  logic                       config_msbFirst,
  input  logic                       config_csManual,
  input  logic                       config_csLevel,
  input  logic [7:0]                 tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [7:0]                 rx_data,
  output logic                       rx_valid,
  output logic                       busy,
  output logic                       spi_clk,
  output logic                       spi_mosi,
  input  logic                       spi_miso,
  output logic                       spi_cs
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t                     state, state_next;
  logic [CLOCK_DIV_WIDTH-1:0] div_q, cnt;
  logic                       cpol_q, cpha_q, msb_q;
  logic [7:0]                 tx_sr, rx_sr;
  logic [3:0]                 edge_cnt;
  logic [4:0]                 edge_idx;
  logic                       accept, tick, leading, last_edge;
  logic                       edge_now, finish, do_sample, do_shift, cs_next;

  assign tx_ready  = config_enable && (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = tx_valid && tx_ready;
  assign tick      = (cnt == '0);
  // edge_idx is the 1-based number of the edge about to be produced; odd edges are leading
  assign edge_idx  = {1'b0, edge_cnt} + 5'd1;
  assign leading   = edge_idx[0];
  assign last_edge = (edge_cnt == 4'd15);

  always_comb begin
    state_next = state;
    edge_now   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE:  if (accept) state_next = SETUP;
      SETUP: if (tick) begin
               edge_now   = 1'b1;
               state_next = SHIFT;
             end
      SHIFT: if (tick) begin
               edge_now = 1'b1;
               if (last_edge) state_next = HOLD;
             end
      HOLD:  if (tick) begin
               finish     = 1'b1;
               state_next = IDLE;
             end
      default: state_next = IDLE;
    endcase
    if (!config_enable && state != IDLE) begin
      state_next = IDLE;
      edge_now   = 1'b0;
      finish     = 1'b0;
    end
    do_sample = edge_now && (leading ^ cpha_q);
    // CPHA=1 edge 1 re-drives the bit already on MOSI, so no shift is needed there
    do_shift  = edge_now && !(leading ^ cpha_q) && (edge_idx != 5'd1) && !last_edge;
    cs_next   = config_csManual ? !config_csLevel : (state_next == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      div_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      msb_q    <= 1'b0;
      tx_sr    <= 8'h00;
      rx_sr    <= 8'h00;
      edge_cnt <= 4'd0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs   <= 1'b1;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_next;
      rx_valid <= finish;
      spi_cs   <= cs_next;
      if (finish) rx_data <= rx_sr;

      if (state == IDLE)            spi_clk <= config_cpol;
      else if (state_next == IDLE)  spi_clk <= cpol_q;
      else if (edge_now)            spi_clk <= ~spi_clk;

      if (accept) begin
        cnt      <= config_clockDivider;
        div_q    <= config_clockDivider;
        cpol_q   <= config_cpol;
        cpha_q   <= config_cpha;
        msb_q    <= config_msbFirst;
        edge_cnt <= 4'd0;
        tx_sr    <= tx_data;
        rx_sr    <= 8'h00;
        spi_mosi <= config_msbFirst ? tx_data[7] : tx_data[0];
      end else if (state != IDLE) begin
        cnt <= tick ? div_q : cnt - 1'b1;
        if (edge_now) edge_cnt <= edge_cnt + 4'd1;
        if (do_sample)
          rx_sr <= msb_q ? {rx_sr[6:0], spi_miso} : {spi_miso, rx_sr[7:1]};
        if (do_shift) begin
          tx_sr    <= msb_q ? {tx_sr[6:0], 1'b0} : {1'b0, tx_sr[7:1]};
          spi_mosi <= msb_q ? tx_sr[6] : tx_sr[1];
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
`timescale 1ns/1ps
// Bench for spi_master_core: directed bytes against a behavioural SPI slave, with a
// scoreboard queue of expected rx bytes/latencies checked by a separate rx monitor.
module tb_spi_master_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       config_enable = 1'b0;
  logic [7:0] config_clockDivider = 8'd7;
  logic       config_cpol = 1'b0;
  logic       config_cpha = 1'b0;
  logic       config_msbFirst = 1'b1;
  logic       config_csManual = 1'b0;
  logic       config_csLevel = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;
  logic       spi_cs;

  spi_master_core #(.CLOCK_DIV_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .config_enable(config_enable),
    .config_clockDivider(config_clockDivider), .config_cpol(config_cpol),
    .config_cpha(config_cpha), .config_msbFirst(config_msbFirst),
    .config_csManual(config_csManual), .config_csLevel(config_csLevel),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs(spi_cs)
  );

  always #12.5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         acc;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] slave_q[$];
  logic [7:0] slave_rx_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int cs_err = 0;
  int cs_hi = 0;
  int sck_edges = 0;
  int cur_div = 7;
  bit man_win = 0;
  real tr = 0.0, tr_prev = 0.0, tf = 0.0, tf_prev = 0.0;

  logic       m_cpol = 1'b0, m_cpha = 1'b0, m_csman = 1'b0, s_msb = 1'b1;
  logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
  int         s_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic bitof(input logic [7:0] b, input int i);
    return s_msb ? b[7-i] : b[i];
  endfunction

  always @(posedge clk) cyc++;

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      rx_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rx_valid actual=%0h required=none", rx_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_data", rx_data, e.data);
        chk("rx_latency", cyc - e.acc, e.lat);
      end
    end
    if (busy && !config_csManual && spi_cs) cs_err++;
    if (man_win && spi_cs) cs_hi++;
  end

  always @(posedge spi_clk) begin tr_prev = tr; tr = $realtime; end
  always @(negedge spi_clk) begin tf_prev = tf; tf = $realtime; end
  always @(spi_clk) if (busy) sck_edges++;

  // behavioural slave
  always @(negedge spi_cs) begin
    s_cnt = 0;
    s_rx = 8'h00;
    if (slave_q.size() > 0) s_tx = slave_q.pop_front();
    if (!m_cpha) spi_miso = bitof(s_tx, 0);
  end

  always @(spi_clk) begin
    if (spi_cs === 1'b0) begin
      if ((spi_clk !== m_cpol) ^ m_cpha) begin
        s_rx = s_msb ? {s_rx[6:0], spi_mosi} : {spi_mosi, s_rx[7:1]};
        s_cnt++;
        if (s_cnt == 8) begin
          slave_rx_q.push_back(s_rx);
          s_cnt = 0;
          s_rx = 8'h00;
          if (m_csman && slave_q.size() > 0) s_tx = slave_q.pop_front();
        end
      end else begin
        spi_miso = bitof(s_tx, s_cnt);
      end
    end
  end

  task automatic set_cfg(input logic cpol, input logic cpha, input logic msb, input int div);
    @(negedge clk);
    config_cpol = cpol; config_cpha = cpha; config_msbFirst = msb;
    config_clockDivider = 8'(div);
    m_cpol = cpol; m_cpha = cpha; cur_div = div;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] exp_rx, input bit push,
                      output logic rv_at_acc);
    int n;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=no_ready required=ready");
    end
    rv_at_acc = rx_valid;
    if (push) exp_q.push_back('{data: exp_rx, acc: cyc, lat: 17*(cur_div+1)+1});
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    for (int i = 0; i < 1000 && rx_cnt < target; i++) @(negedge clk);
    chk("rx_count", rx_cnt, target);
  endtask

  task automatic chk_slave(input string name, input logic [7:0] req);
    if (slave_rx_q.size() == 0) chk(name, 32'hFFFF_FFFF, req);
    else chk(name, slave_rx_q.pop_front(), req);
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < 1000 && sck_edges < n; i++) @(negedge clk);
    chk("sck_edge_wait", sck_edges, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rv, rv2;
    int rdy_seen;

    repeat (3) @(negedge clk);
    chk("rst_spi_clk", spi_clk, 0);
    chk("rst_spi_mosi", spi_mosi, 0);
    chk("rst_spi_cs", spi_cs, 1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_ready_dis", tx_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    config_enable = 1'b1;
    @(negedge clk);
    chk("tx_ready_en", tx_ready, 1);

    // mode 0, D=7, MSB first
    set_cfg(0, 0, 1, 7);
    s_msb = 1'b1;
    slave_q.push_back(8'hC5);
    send(8'h1F, 8'hC5, 1, rv);
    wait_rx(1);
    chk_slave("slave_rx_m0", 8'h1F);
    chk_rng("sck_period_d7", int'(tr - tr_prev), 390, 410);
    chk_rng("sck_low_d7", int'(tr - tf_prev), 190, 210);
    chk("cs_low_busy_m0", cs_err, 0);

    // D=0
    set_cfg(0, 0, 1, 0);
    slave_q.push_back(8'h3E);
    send(8'h5C, 8'h3E, 1, rv);
    wait_rx(2);
    chk_slave("slave_rx_d0", 8'h5C);
    chk_rng("sck_period_d0", int'(tr - tr_prev), 45, 55);

    // mode 3, with tx_valid pulsed while busy
    set_cfg(1, 1, 1, 7);
    repeat (3) @(negedge clk);
    chk("sck_idle_cpol1", spi_clk, 1);
    slave_q.push_back(8'h5A);
    send(8'h83, 8'h5A, 1, rv);
    repeat (20) @(negedge clk);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    rdy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_ready) rdy_seen++;
    end
    tx_valid = 1'b0;
    chk("ready_while_busy", rdy_seen, 0);
    wait_rx(3);
    chk_slave("slave_rx_m3", 8'h83);
    repeat (200) @(negedge clk);
    chk("no_extra_rx_m3", rx_cnt, 3);

    // LSB first; slave shifts MSB first so the received byte comes back bit-reversed
    set_cfg(0, 0, 0, 3);
    slave_q.push_back(8'hC5);
    send(8'h01, 8'hA3, 1, rv);
    chk("first_mosi_lsb", spi_mosi, 1);
    wait_rx(4);
    chk_slave("slave_rx_lsb", 8'h80);

    // manual CS, two bytes back to back
    set_cfg(0, 0, 1, 1);
    slave_q.push_back(8'h6E);
    slave_q.push_back(8'h2D);
    m_csman = 1'b1;
    config_csManual = 1'b1;
    config_csLevel = 1'b1;
    repeat (3) @(negedge clk);
    chk("cs_manual_low", spi_cs, 0);
    man_win = 1;
    send(8'hA3, 8'h6E, 1, rv);
    send(8'h9B, 8'h2D, 1, rv2);
    chk("b2b_accept_in_rx_valid", rv2, 1);
    wait_rx(6);
    @(negedge clk);
    man_win = 0;
    chk("cs_manual_never_high", cs_hi, 0);
    chk_slave("slave_rx_man1", 8'hA3);
    chk_slave("slave_rx_man2", 8'h9B);
    config_csLevel = 1'b0;
    repeat (3) @(negedge clk);
    chk("cs_manual_release", spi_cs, 1);
    config_csManual = 1'b0;
    m_csman = 1'b0;

    // abort by dropping enable at edge 5
    set_cfg(0, 0, 1, 7);
    slave_q.push_back(8'h99);
    sck_edges = 0;
    send(8'h55, 8'h00, 0, rv);
    wait_edges(5);
    chk("abort_sck_before", spi_clk, 1);
    config_enable = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_cs", spi_cs, 1);
    chk("abort_sck", spi_clk, 0);
    chk("abort_rx_data_held", rx_data, 8'h2D);
    repeat (200) @(negedge clk);
    chk("abort_no_rx_valid", rx_cnt, 6);
    config_enable = 1'b1;
    repeat (2) @(negedge clk);

    // asynchronous reset mid-SHIFT
    slave_q.push_back(8'h00);
    sck_edges = 0;
    send(8'hF0, 8'h00, 0, rv);
    wait_edges(5);
    chk("pre_rst_mosi", spi_mosi, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_spi_clk", spi_clk, 0);
    chk("arst_spi_mosi", spi_mosi, 0);
    chk("arst_spi_cs", spi_cs, 1);
    chk("arst_busy", busy, 0);
    chk("arst_rx_valid", rx_valid, 0);
    chk("arst_rx_data", rx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    chk("cs_low_busy_all", cs_err, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_core.md
# spi_master_core

Byte-oriented SPI master engine for the peripherals block. It sits between the peripheral's register and Wishbone front end and the SPI pads (sck, mosi, miso, cs). It accepts one byte at a time over a valid/ready handshake and shifts it out in any of the four CPOL/CPHA modes at a programmable SCK rate. It returns the byte captured from MISO together with a one-cycle strobe.

## Interface
Parameters:
- CLOCK_DIV_WIDTH, 8, width of the half-period divider field.

Ports:
- clk  in  1  system clock, 40 MHz nominal.
- rst_n  in  1  asynchronous, active-low reset. One clock domain only.
- config_enable  in  1  core enable. Deasserting it aborts any transfer.
- config_clockDivider  in  CLOCK_DIV_WIDTH  D. One SCK half-period lasts D+1 clk cycles.
- config_cpol  in  1  SCK idle level.
- config_cpha  in  1  0: sample on leading edge. 1: sample on trailing edge.
- config_msbFirst  in  1  bit order for both TX and RX.
- config_csManual  in  1  0: CS is driven automatically per byte. 1: CS follows config_csLevel.
- config_csLevel  in  1  in manual mode, 1 drives spi_cs low (asserted).
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  equals config_enable && state==IDLE.
- rx_data  out  8  last received byte. Held until the next completion.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  high in every state other than IDLE.
- spi_clk  out  1  SCK, registered.
- spi_mosi  out  1  registered.
- spi_miso  in  1  sampled at the SCK sampling edge.
- spi_cs  out  1  chip select, active low, registered.

## Operation
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE: spi_clk = config_cpol, tracked every cycle. spi_cs is high in auto mode and equals !config_csLevel in manual mode.
- Accept: tx_valid && tx_ready. On accept the core latches tx_data, D, cpol, cpha and msbFirst. Config changes during a transfer are ignored until the next accept.
- SETUP, D+1 cycles: CS is asserted (auto mode). spi_mosi presents the first bit: tx_data[7] if msbFirst, else tx_data[0].
- SHIFT: 16 SCK edges, each D+1 cycles apart. An edge counter of 0..15 marks odd edges as leading and even edges as trailing.
  - CPHA=0: sample MISO on leading edges. Drive the next MOSI bit on trailing edges, except after the last one.
  - CPHA=1: drive MOSI on leading edges, with the first bit re-driven on edge 1. Sample MISO on trailing edges.
- Sampled bits enter the RX shift register from the right when msbFirst, otherwise from the left.
- HOLD, D+1 cycles: SCK stays at cpol. At the end of HOLD: rx_data <= shift register, rx_valid=1 for one cycle, state returns to IDLE, and CS deasserts in auto mode.
- Back-to-back: a new accept is allowed in the IDLE cycle that carries rx_valid. In auto mode CS is high for at least 1 cycle between bytes.
- Manual CS mode: CS is never toggled by the state machine, so multi-byte frames keep CS low.
- config_enable dropping in any non-IDLE state forces IDLE on the next cycle:
  - spi_clk = cpol, CS deasserted in auto mode.
  - No rx_valid, rx_data unchanged.
- tx_valid while busy is ignored. No queueing.
- D=0 is legal: each half-period is 1 cycle, giving SCK = clk/2.

## Timing
- Reset values: spi_clk=0, spi_mosi=0, spi_cs=1, rx_data=8'h00, rx_valid=0, busy=0, state IDLE.
- After reset, tx_ready = config_enable.
- Reset mid-transfer returns all outputs to these values asynchronously.
- Accept at cycle 0:
  - busy and CS assertion in cycle 1.
  - SCK edge k (1..16) appears at cycle 1+k*(D+1).
  - rx_valid and CS deassertion at cycle 1+17*(D+1).
- Total latency from accept to rx_valid is 17*(D+1)+1 cycles.
- SCK period is 2*(D+1) clk cycles. At 40 MHz with D=7: 200 ns low, 400 ns period.
- MISO is captured on the clk edge that registers the sampling SCK transition.
- The core adds no MISO synchronizer; the pad wrapper provides one.

## Test plan
- Mode 0, D=7, MSB first, auto CS, tx 8'h1F, slave returns 8'hC5:
  - slave receives 8'h1F, CS low for the whole transfer.
  - rx_data=8'hC5 with rx_valid after 137 cycles.
- Mode 3 (cpol=1, cpha=1), tx 8'h83:
  - SCK idles high, slave sampling on the rising edge receives 8'h83.
  - rx byte matches the slave's shifted value.
- Timing at D=7: SCK low time 200 ns ±10 ns, period 400 ns ±10 ns. With D=0: SCK period 50 ns.
- Manual CS, config_csLevel=1, two bytes 8'hA3 then 8'h9B:
  - CS stays low across both bytes.
  - Second accept taken in the rx_valid cycle.
- LSB first, tx 8'h01: first MOSI bit is 1, and rx bit order is reversed relative to MSB-first.
- Abort and reset:
  - Drop config_enable at edge 5: IDLE next cycle, CS high, no rx_valid, spi_clk=cpol.
  - Assert rst_n low mid-SHIFT: outputs go to reset values immediately.
  - tx_valid while busy is ignored.
